bomb_controller: RTL and testbench
==================================

BOMB_CONTROLLER -- requirements
Module: bomb_controller

Interface
REQ-001 The module SHALL have parameter FUSE_CYCLES, default 200000000, meaning clock cycles from bomb drop to detonation (at least 2).
REQ-002 The module SHALL have parameter EXPLODE_CYCLES, default 50000000, meaning clock cycles the explosion is displayed (at least 1).
REQ-003 The module SHALL have parameter X_ORIGIN, default 143, meaning the left pixel of the tile grid.
REQ-004 The module SHALL have parameter Y_ORIGIN, default 34, meaning the top pixel of the tile grid.
REQ-005 Port clk SHALL be an input, 1 bit: system clock; all state changes on its rising edge.
REQ-006 Port reset SHALL be an input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port C SHALL be an input, 1 bit: debounced drop-bomb button, level.
REQ-008 Port game_over SHALL be an input, 1 bit: game ended.
REQ-009 Ports b_x and b_y SHALL be inputs, 10 bits each: top-left pixel of the player sprite.
REQ-010 Ports v_x and v_y SHALL be inputs, 10 bits each: current VGA pixel.
REQ-011 Ports e_x and e_y SHALL be outputs, 10 bits each: top-left pixel of the bomb/explosion centre tile.
REQ-012 Port explosion_SCEN SHALL be an output, 1 bit: single-cycle detonation pulse.
REQ-013 Port bomb_active SHALL be an output, 1 bit: high in ARMED or EXPLODE.
REQ-014 Ports bomb_on and exp_on SHALL be outputs, 1 bit each: the current pixel lies inside the bomb sprite or the explosion plus.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, ARMED and EXPLODE; any illegal encoding SHALL go to IDLE.
REQ-016 A drop SHALL be a rising edge of C (C=1, with the registered previous C=0) sampled in IDLE while game_over=0.
REQ-017 A rising edge of C in ARMED or EXPLODE, or while game_over=1, SHALL be ignored and SHALL NOT be queued.
REQ-018 On a drop in cycle t, the block SHALL latch e_x = X_ORIGIN + ((b_x - X_ORIGIN + 8) >> 4 << 4), and e_y the same using b_y and Y_ORIGIN, with 10-bit modulo arithmetic.
REQ-019 On that drop, the state SHALL be ARMED from cycle t+1.
REQ-020 e_x and e_y SHALL hold constant from the latch until the next drop.
REQ-021 explosion_SCEN SHALL be high for exactly one cycle, t+FUSE_CYCLES; EXPLODE SHALL begin in that same cycle.
REQ-022 EXPLODE SHALL last exactly EXPLODE_CYCLES cycles; the state SHALL then be IDLE, and a drop SHALL be accepted in the first IDLE cycle.
REQ-023 The fuse/explode counter SHALL be 28 bits, SHALL be cleared on every state change, and SHALL never wrap.
REQ-024 game_over rising while a bomb is in flight SHALL NOT abort or alter the sequence.
REQ-025 bomb_on SHALL be combinational: state==ARMED, e_x <= v_x <= e_x+15, and e_y <= v_y <= e_y+15.
REQ-026 exp_on SHALL be combinational and high in EXPLODE when the pixel lies in either beam of the plus.
- Horizontal beam: v_y in [e_y, e_y+15] and v_x+48 >= e_x and v_x <= e_x+63.
- Vertical beam: v_x in [e_x, e_x+15] and v_y+48 >= e_y and v_y <= e_y+63.
REQ-027 The comparisons in REQ-026 SHALL use 11-bit arithmetic so that no underflow occurs.

Reset
REQ-028 While reset=1, the block SHALL hold: state IDLE, counter 0, e_x=0, e_y=0, explosion_SCEN=0, bomb_active=0, bomb_on=0, exp_on=0.
REQ-029 Reset SHALL set the registered previous C to 1, so a button held through reset release SHALL NOT drop a bomb.
REQ-030 Reset asserted in ARMED or EXPLODE SHALL abort immediately, and explosion_SCEN SHALL NOT pulse.

Configuration
REQ-031 With macro BOMB_REMOTE_DETONATE_EN defined, a C rising edge in ARMED at cycle u (u > t+1) SHALL pulse explosion_SCEN at cycle u+1 and enter EXPLODE at cycle u+1, with the fuse abandoned.
REQ-032 Without BOMB_REMOTE_DETONATE_EN, such an edge SHALL be ignored per REQ-017, and no remote-detonate logic SHALL be synthesized.

Verification
REQ-033 The bench SHALL run with FUSE_CYCLES=10 and EXPLODE_CYCLES=5 and cover the following scenarios.
REQ-034 Scenario 1: b_x=150, b_y=40, C pulse at cycle 3 -> e_x=143, e_y=34; bomb_active high from cycle 4; explosion_SCEN high only at cycle 13; IDLE at cycle 18.
REQ-035 Scenario 2: b_x=152, b_y=43, drop -> e_x=159, e_y=50.
REQ-036 Scenario 3: second C edge at cycle 7 (macro undefined) -> e_x/e_y unchanged and the single pulse still at cycle 13. With the macro defined -> pulse at cycle 8 and IDLE at cycle 13.
REQ-037 Scenario 4: C held high across reset release -> no drop. game_over=1 with a C edge -> no drop. game_over raised at cycle 6 of a fuse -> pulse still at cycle 13.
REQ-038 Scenario 5: reset asserted at cycle 9 of a fuse -> outputs 0 within the same cycle and no pulse; after release, a C edge drops normally.
REQ-039 Scenario 6: EXPLODE with e_x=200, e_y=100 -> exp_on is 1 at (152,100), (263,115), (200,52), (215,163); 0 at (151,100), (216,116) and (199,52).

Source files
------------

// File: rtl/bomb_controller.sv
// bomb_controller: single-bomb drop / fuse / explosion sequencer for a tile-based VGA game.
//
// A rising edge of the drop button while idle (and the game still running) snaps the
// player's position to the 16-pixel tile grid and arms a bomb there. After FUSE_CYCLES
// cycles (counted from the drop cycle) the bomb detonates: explosion_SCEN pulses for one
// cycle and the explosion plus is shown for EXPLODE_CYCLES cycles before returning to idle.
//
// Optional feature (compile-time macro BOMB_REMOTE_DETONATE_EN):
//   when defined, a fresh rising edge of C while ARMED detonates the bomb on the next
//   cycle instead of waiting for the fuse. When undefined the logic is not built at all.
//
// Parameters:
//   FUSE_CYCLES    cycles from drop to detonation (>= 2)
//   EXPLODE_CYCLES cycles the explosion is displayed (>= 1)
//   X_ORIGIN       left pixel of the tile grid
//   Y_ORIGIN       top pixel of the tile grid
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   C               debounced drop-bomb button (level)
//   game_over       game ended; blocks new drops only
//   b_x, b_y        top-left pixel of the player sprite
//   v_x, v_y        current VGA pixel
//   e_x, e_y        top-left pixel of the bomb / explosion centre tile
//   explosion_SCEN  single-cycle detonation pulse
//   bomb_active     high while ARMED or EXPLODE
//   bomb_on         current pixel lies in the bomb sprite
//   exp_on          current pixel lies in the explosion plus
module bomb_controller #(
    parameter int unsigned FUSE_CYCLES    = 200000000,
    parameter int unsigned EXPLODE_CYCLES = 50000000,
    parameter int unsigned X_ORIGIN       = 143,
    parameter int unsigned Y_ORIGIN       = 34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       C,
    input  logic       game_over,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] v_x,
    input  logic [9:0] v_y,
    output logic [9:0] e_x,
    output logic [9:0] e_y,
    output logic       explosion_SCEN,
    output logic       bomb_active,
    output logic       bomb_on,
    output logic       exp_on
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StArmed   = 2'b01,
        StExplode = 2'b10
    } state_e;

    // The drop cycle itself counts toward the fuse, so ARMED lasts FUSE_CYCLES-1 cycles.
    localparam logic [27:0] FuseLast    = 28'(FUSE_CYCLES - 2);
    localparam logic [27:0] ExplodeLast = 28'(EXPLODE_CYCLES - 1);
    localparam logic [27:0] CntMax      = '1;
    localparam logic [9:0]  XOrg        = 10'(X_ORIGIN);
    localparam logic [9:0]  YOrg        = 10'(Y_ORIGIN);

    state_e      state_q, state_d;
    logic [27:0] cnt_q, cnt_d;
    logic        c_prev_q;
    logic [9:0]  e_x_q, e_x_d;
    logic [9:0]  e_y_q, e_y_d;
    logic        c_rise;
    logic        latch_pos;

    // Grid snap: round to the nearest tile relative to the origin (10-bit wraparound).
    logic [9:0] rel_x, rel_y;
    assign rel_x = b_x - XOrg + 10'd8;
    assign rel_y = b_y - YOrg + 10'd8;

    assign c_rise = C & ~c_prev_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        latch_pos = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (c_rise && !game_over) begin
                    state_d   = StArmed;
                    latch_pos = 1'b1;
                end
            end
            StArmed: begin
                if (cnt_q == FuseLast) begin
                    state_d = StExplode;
                end
`ifdef BOMB_REMOTE_DETONATE_EN
                // Second press while armed detonates early; the fuse is abandoned.
                if (c_rise) begin
                    state_d = StExplode;
                end
`endif
            end
            StExplode: begin
                if (cnt_q == ExplodeLast) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Counter restarts on every state change and saturates rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 28'd1;
        end
    end

    always_comb begin
        e_x_d = e_x_q;
        e_y_d = e_y_q;
        if (latch_pos) begin
            e_x_d = XOrg + {rel_x[9:4], 4'b0000};
            e_y_d = YOrg + {rel_y[9:4], 4'b0000};
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            // Preset high so a button held through reset release is not seen as an edge.
            c_prev_q <= 1'b1;
            e_x_q    <= '0;
            e_y_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            c_prev_q <= C;
            e_x_q    <= e_x_d;
            e_y_q    <= e_y_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic is_armed, is_explode;
    assign is_armed   = (state_q == StArmed);
    assign is_explode = (state_q == StExplode);

    assign e_x         = e_x_q;
    assign e_y         = e_y_q;
    assign bomb_active = is_armed | is_explode;
    // EXPLODE is always entered with a cleared counter, so count 0 marks its first cycle.
    assign explosion_SCEN = is_explode && (cnt_q == '0);

    // Pixel tests widened to 11 bits so e_x+63 and v_x+48 cannot wrap.
    logic [10:0] vx11, vy11, ex11, ey11;
    logic        in_col, in_row, h_beam, v_beam;

    assign vx11 = {1'b0, v_x};
    assign vy11 = {1'b0, v_y};
    assign ex11 = {1'b0, e_x_q};
    assign ey11 = {1'b0, e_y_q};

    assign in_col = (vx11 >= ex11) && (vx11 <= ex11 + 11'd15);
    assign in_row = (vy11 >= ey11) && (vy11 <= ey11 + 11'd15);
    assign h_beam = in_row && (vx11 + 11'd48 >= ex11) && (vx11 <= ex11 + 11'd63);
    assign v_beam = in_col && (vy11 + 11'd48 >= ey11) && (vy11 <= ey11 + 11'd63);

    assign bomb_on = is_armed && in_col && in_row;
    assign exp_on  = is_explode && (h_beam || v_beam);

endmodule

// File: tb/tb_bomb_controller.sv
`timescale 1ns/1ps
module tb_bomb_controller;

    localparam int F = 10;
    localparam int E = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       C = 1'b1;
    logic       game_over = 1'b0;
    logic [9:0] b_x = '0, b_y = '0, v_x = '0, v_y = '0;
    logic [9:0] e_x, e_y;
    logic       explosion_SCEN, bomb_active, bomb_on, exp_on;

    // Second instance with a grid origin that makes the (200,100) centre reachable.
    logic       c6 = 1'b0;
    logic [9:0] b6_x = 10'd200, b6_y = 10'd100;
    logic [9:0] e6_x, e6_y;
    logic       scen6, active6, bomb_on6, exp_on6;

    bomb_controller #(
        .FUSE_CYCLES(F), .EXPLODE_CYCLES(E), .X_ORIGIN(143), .Y_ORIGIN(34)
    ) dut (
        .clk(clk), .reset(reset), .C(C), .game_over(game_over),
        .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
        .e_x(e_x), .e_y(e_y), .explosion_SCEN(explosion_SCEN),
        .bomb_active(bomb_active), .bomb_on(bomb_on), .exp_on(exp_on)
    );

    bomb_controller #(
        .FUSE_CYCLES(F), .EXPLODE_CYCLES(E), .X_ORIGIN(200), .Y_ORIGIN(100)
    ) dut6 (
        .clk(clk), .reset(reset), .C(c6), .game_over(game_over),
        .b_x(b6_x), .b_y(b6_y), .v_x(v_x), .v_y(v_y),
        .e_x(e6_x), .e_y(e6_y), .explosion_SCEN(scen6),
        .bomb_active(active6), .bomb_on(bomb_on6), .exp_on(exp_on6)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    // Reference model: the current bomb is described by its drop, pulse and end cycles.
    int t_drop, pulse_cyc, end_cyc;
    int ex_now, ey_now, ex_next, ey_next;
    bit c_prev_m;
    int bxs = 0, bys = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int snap(input int b, input int o);
        int rel;
        rel = (((b - o + 8) % 1024) + 1024) % 1024;
        return ((rel / 16) * 16 + o) % 1024;
    endfunction

    function automatic bit m_armed();
        return t_drop >= 0 && cyc > t_drop && cyc < pulse_cyc;
    endfunction

    function automatic bit m_explode();
        return t_drop >= 0 && cyc >= pulse_cyc && cyc < end_cyc;
    endfunction

    function automatic bit in_box(input int vx, input int vy, input int ex, input int ey);
        return vx >= ex && vx <= ex + 15 && vy >= ey && vy <= ey + 15;
    endfunction

    function automatic bit in_plus(input int vx, input int vy, input int ex, input int ey);
        bit h, v;
        h = vy >= ey && vy <= ey + 15 && vx + 48 >= ex && vx <= ex + 63;
        v = vx >= ex && vx <= ex + 15 && vy + 48 >= ey && vy <= ey + 63;
        return h || v;
    endfunction

    task automatic model_reset();
        t_drop = -1; pulse_cyc = -1; end_cyc = -1;
        ex_now = 0; ey_now = 0; ex_next = 0; ey_next = 0;
        c_prev_m = 1'b1;
    endtask

    // Hold reset, check the reset state, then release mid-cycle; that cycle is cycle 0.
    task automatic start(input bit c_hold);
        reset = 1'b1;
        C = c_hold;
        game_over = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_active", bomb_active, 0);
        check("rst_scen", explosion_SCEN, 0);
        check("rst_ex", e_x, 0);
        check("rst_ey", e_y, 0);
        reset = 1'b0;
        cyc = 0;
        c_prev_m = c_hold;
    endtask

    task automatic run_cycle(input bit c, input bit go);
        int dx, dy;
        bit rise;
        @(posedge clk);
        #1;
        cyc++;
        ex_now = ex_next;
        ey_now = ey_next;
        C = c;
        game_over = go;
        b_x = 10'(bxs);
        b_y = 10'(bys);
        dx = int'($urandom_range(110)) - 40;
        dy = int'($urandom_range(110)) - 40;
        v_x = 10'((ex_now + dx + 1024) % 1024);
        v_y = 10'((ey_now + dy + 1024) % 1024);
        rise = c && !c_prev_m;
        if (rise && !go && !m_armed() && !m_explode()) begin
            t_drop = cyc;
            pulse_cyc = cyc + F;
            end_cyc = cyc + F + E;
            ex_next = snap(bxs, 143);
            ey_next = snap(bys, 34);
        end
`ifdef BOMB_REMOTE_DETONATE_EN
        else if (rise && m_armed()) begin
            pulse_cyc = cyc + 1;
            end_cyc = cyc + 1 + E;
        end
`endif
        c_prev_m = c;
        @(negedge clk);
        check("bomb_active", bomb_active, (m_armed() || m_explode()) ? 1 : 0);
        check("explosion_SCEN", explosion_SCEN, (t_drop >= 0 && cyc == pulse_cyc) ? 1 : 0);
        check("e_x", e_x, ex_now);
        check("e_y", e_y, ey_now);
        check("bomb_on", bomb_on, (m_armed() && in_box(v_x, v_y, ex_now, ey_now)) ? 1 : 0);
        check("exp_on", exp_on, (m_explode() && in_plus(v_x, v_y, ex_now, ey_now)) ? 1 : 0);
    endtask

    task automatic run_n(input int n, input bit go);
        for (int i = 0; i < n; i++) run_cycle(1'b0, go);
    endtask

    task automatic probe6(input int vx, input int vy, input bit exp);
        v_x = 10'(vx);
        v_y = 10'(vy);
        #0.5;
        check("s6_exp_on", exp_on6, exp);
    endtask

    initial begin
        model_reset();

        // Scenario 1: basic drop at cycle 3, snapped to the origin tile.
        start(1'b0);
        bxs = 150; bys = 40;
        run_n(2, 1'b0);
        run_cycle(1'b1, 1'b0);
        run_n(16, 1'b0);
        check("s1_ex", e_x, 143);
        check("s1_ey", e_y, 34);

        // Scenario 2: rounding up into the next tile.
        bxs = 152; bys = 43;
        run_cycle(1'b1, 1'b0);
        run_n(16, 1'b0);
        check("s2_ex", e_x, 159);
        check("s2_ey", e_y, 50);

        // Scenario 3: second press while armed (position must not change).
        start(1'b0);
        bxs = 150; bys = 40;
        run_n(2, 1'b0);
        run_cycle(1'b1, 1'b0);
        run_n(3, 1'b0);
        bxs = 300; bys = 300;
        run_cycle(1'b1, 1'b0);
        run_n(14, 1'b0);
        check("s3_ex", e_x, 143);
        check("s3_ey", e_y, 34);

        // Scenario 4a: button held across reset release.
        start(1'b1);
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b0);
        run_n(3, 1'b0);
        check("s4_held", bomb_active, 0);
        // Scenario 4b: press while game over.
        run_cycle(1'b0, 1'b1);
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b0);
        run_n(3, 1'b1);
        check("s4_gameover", bomb_active, 0);
        // Scenario 4c: game over raised mid-fuse.
        start(1'b0);
        bxs = 150; bys = 40;
        run_n(2, 1'b0);
        run_cycle(1'b1, 1'b0);
        run_n(2, 1'b0);
        run_n(14, 1'b1);

        // Scenario 5: reset during the fuse aborts at once.
        start(1'b0);
        run_n(2, 1'b0);
        run_cycle(1'b1, 1'b0);
        run_n(5, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("s5_active", bomb_active, 0);
        check("s5_scen", explosion_SCEN, 0);
        check("s5_ex", e_x, 0);
        check("s5_bomb_on", bomb_on, 0);
        start(1'b0);
        run_n(8, 1'b0);
        bxs = 152; bys = 43;
        run_cycle(1'b1, 1'b0);
        run_n(16, 1'b0);
        check("s5_redrop_ex", e_x, 159);

        // Scenario 6: explosion plus geometry around (200,100).
        start(1'b0);
        run_cycle(1'b0, 1'b0);
        c6 = 1'b1;
        run_cycle(1'b0, 1'b0);
        c6 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (scen6) break;
            run_cycle(1'b0, 1'b0);
        end
        check("s6_pulse", scen6, 1);
        check("s6_ex", e6_x, 200);
        check("s6_ey", e6_y, 100);
        probe6(152, 100, 1'b1);
        probe6(263, 115, 1'b1);
        probe6(200, 52, 1'b1);
        probe6(215, 163, 1'b1);
        probe6(151, 100, 1'b0);
        probe6(216, 116, 1'b0);
        probe6(199, 52, 1'b0);
        run_n(8, 1'b0);

        // Random phase: random presses, game-over and player positions against the model.
        start(1'b0);
        for (int i = 0; i < 400; i++) begin
            bxs = int'($urandom_range(1023));
            bys = int'($urandom_range(1023));
            run_cycle(($urandom_range(3) == 0), ($urandom_range(7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
